// File: rtl/isa_pkg.sv
// Shared ISA types for the 14-bit datapath: instruction fields, ALU opcodes, issuer states.
package isa_pkg;

  localparam int INSTR_W = 14;
  localparam int REG_AW  = 4;
  localparam int OP_W    = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e             op;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rn;
    logic [REG_AW-1:0]   rm;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/instr_mem.sv
// Program store: DEPTH x W register array.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none; the caller gates the write enable.
module instr_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int W      = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents survive reset so a halted or reset program can be reloaded cheaply.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Loads a program over a valid/ready port and issues it in order; ISSUE_HAZARD_EN adds a RAW interlock.
// Latency: instr at pc is presented combinationally; one instruction per accepted cycle, done one cycle after the last.
// Backpressure: instr/pc hold while issue_valid & ~issue_ready; load_ready drops when full, clearing or running.
module instr_issuer
  import isa_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int HAZ_GAP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_clear,
  input  logic               start,
  input  logic               halt,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W:0]    count,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  issuer_state_e state_q, state_d;
  logic          load_fire, start_ok, accept, last_slot, hazard;

  assign load_fire = load_valid & load_ready;
  assign start_ok  = (state_q == S_IDLE) & start & ~load_clear & ~load_fire & (count != '0);
  assign accept    = issue_valid & issue_ready & ~halt;
  assign last_slot = ({1'b0, pc} == (count - 1'b1));
  assign busy      = (state_q != S_IDLE);

  instr_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(INSTR_W)) u_mem (
    .clk   (clk),
    .we    (load_fire),
    .waddr (count[ADDR_W-1:0]),
    .wdata (load_data),
    .raddr (pc),
    .rdata (instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (halt)                    state_d = S_IDLE;
        else if (accept && last_slot) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready  = 1'b0;
    issue_valid = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE:  load_ready  = (count < DEPTH_C) & ~load_clear;
      S_RUN:   issue_valid = ~hazard;
      S_DONE:  done        = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      count <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pc <= '0;
          if (load_clear)     count <= '0;
          else if (load_fire) count <= count + 1'b1;
        end
        S_RUN: begin
          if (halt)                      pc <= '0;
          else if (accept && !last_slot) pc <= pc + 1'b1;
        end
        default: pc <= '0;
      endcase
    end
  end

`ifdef ISSUE_HAZARD_EN
  localparam int GAP_W = (HAZ_GAP > 1) ? $clog2(HAZ_GAP + 1) : 1;

  logic [GAP_W-1:0]  gap_cnt;
  logic [REG_AW-1:0] last_rd;

  assign hazard = (gap_cnt != '0) &
                  ((instr[7:4] == last_rd) | (instr[3:0] == last_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
      last_rd <= '0;
    end else if (start_ok || (state_q == S_RUN && halt)) begin
      gap_cnt <= '0;
    end else if (accept) begin
      last_rd <= instr[11:8];
      gap_cnt <= GAP_W'(HAZ_GAP);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end
`else
  assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: load, issue, stall, hazard bubble, full/clear, halt and async reset.
module tb_instr_issuer;
  import isa_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                load_valid = 1'b0;
  logic                load_ready;
  logic [INSTR_W-1:0]  load_data = '0;
  logic                load_clear = 1'b0;
  logic                start = 1'b0;
  logic                halt = 1'b0;
  logic                issue_valid;
  logic                issue_ready = 1'b0;
  logic [INSTR_W-1:0]  instr;
  logic [3:0]          pc;
  logic [4:0]          count;
  logic                busy;
  logic                done;

  int vectors = 0;
  int miscompares = 0;

  instr_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_clear(load_clear), .start(start), .halt(halt),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .instr(instr), .pc(pc), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load_beat(input logic [INSTR_W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    check("load_rdy", {31'd0, load_ready}, 32'd1);
    step();
    load_valid = 1'b0;
  endtask

  task automatic do_clear;
    load_clear = 1'b1;
    @(negedge clk);
    check("clr_rdy", {31'd0, load_ready}, 32'd0);
    step();
    load_clear = 1'b0;
  endtask

  task automatic run_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic v, input logic [13:0] ins, input logic [3:0] p);
    @(negedge clk);
    check({tag, "_vld"}, {31'd0, issue_valid}, {31'd0, v});
    if (v) check({tag, "_ins"}, {18'd0, instr}, {18'd0, ins});
    check({tag, "_pc"}, {28'd0, pc}, {28'd0, p});
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  task automatic expect_done_then_idle(input string tag);
    @(negedge clk);
    check({tag, "_dpulse"}, {31'd0, done}, 32'd1);
    check({tag, "_dvld"}, {31'd0, issue_valid}, 32'd0);
    check({tag, "_dbusy"}, {31'd0, busy}, 32'd1);
    step();
    @(negedge clk);
    check({tag, "_idone"}, {31'd0, done}, 32'd0);
    check({tag, "_ibusy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ipc"}, {28'd0, pc}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_vld", {31'd0, issue_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_lrdy", {31'd0, load_ready}, 32'd1);
    check("rst_cnt", {27'd0, count}, 32'd0);
    check("rst_pc", {28'd0, pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Start with an empty program is ignored
    run_start();
    @(negedge clk);
    check("empty_start", {31'd0, busy}, 32'd0);
    step();

    // T1: straight-line issue
    load_beat(14'h0123);
    load_beat(14'h1456);
    load_beat(14'h2789);
    @(negedge clk);
    check("t1_cnt", {27'd0, count}, 32'd3);
    step();
    issue_ready = 1'b1;
    run_start();
    expect_issue("t1_0", 1'b1, 14'h0123, 4'd0); step();
    expect_issue("t1_1", 1'b1, 14'h1456, 4'd1); step();
    expect_issue("t1_2", 1'b1, 14'h2789, 4'd2); step();
    expect_done_then_idle("t1");
    step();

    // T3: stall four cycles at pc=1
    run_start();
    expect_issue("t3_0", 1'b1, 14'h0123, 4'd0); step();
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_issue("t3_hold", 1'b1, 14'h1456, 4'd1);
      step();
    end
    issue_ready = 1'b1;
    expect_issue("t3_1", 1'b1, 14'h1456, 4'd1); step();
    expect_issue("t3_2", 1'b1, 14'h2789, 4'd2); step();
    expect_done_then_idle("t3");
    step();

    // T5: halt at pc=1 while stalled, then rerun
    run_start();
    expect_issue("t5_0", 1'b1, 14'h0123, 4'd0); step();
    issue_ready = 1'b0;
    halt = 1'b1;
    @(negedge clk);
    check("t5_hbusy", {31'd0, busy}, 32'd1);
    step();
    halt = 1'b0;
    @(negedge clk);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_pc", {28'd0, pc}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_cnt", {27'd0, count}, 32'd3);
    step();
    issue_ready = 1'b1;
    run_start();
    expect_issue("t5_r0", 1'b1, 14'h0123, 4'd0); step();
    expect_issue("t5_r1", 1'b1, 14'h1456, 4'd1); step();
    expect_issue("t5_r2", 1'b1, 14'h2789, 4'd2); step();
    expect_done_then_idle("t5");
    step();

    // T2: dependent pair (0x0514 reads r1 written by 0x0123)
    do_clear();
    load_beat(14'h0123);
    load_beat(14'h0514);
    run_start();
    expect_issue("t2_0", 1'b1, 14'h0123, 4'd0); step();
`ifdef ISSUE_HAZARD_EN
    expect_issue("t2_bub", 1'b0, 14'h0514, 4'd1); step();
`endif
    expect_issue("t2_1", 1'b1, 14'h0514, 4'd1); step();
    expect_done_then_idle("t2");
    step();

    // T4: fill to DEPTH, overflow beat refused, start with load beat ignored
    do_clear();
    for (int i = 0; i < 15; i++) load_beat(14'h100 + 14'(i));
    start = 1'b1;
    load_beat(14'h10f);
    start = 1'b0;
    @(negedge clk);
    check("t4_nostart", {31'd0, busy}, 32'd0);
    check("t4_cnt", {27'd0, count}, 32'd16);
    check("t4_full", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b1;
    load_data  = 14'h3fff;
    step();
    load_valid = 1'b0;
    @(negedge clk);
    check("t4_ovf_cnt", {27'd0, count}, 32'd16);
    step();
    do_clear();
    @(negedge clk);
    check("t4_clr_cnt", {27'd0, count}, 32'd0);
    check("t4_clr_rdy", {31'd0, load_ready}, 32'd1);
    step();

    // T6: asynchronous reset mid-RUN
    load_beat(14'h0123);
    load_beat(14'h1456);
    issue_ready = 1'b0;
    run_start();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_vld", {31'd0, issue_valid}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_cnt", {27'd0, count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue_ready = 1'b1;
    run_start();
    @(negedge clk);
    check("t6_nostart", {31'd0, busy}, 32'd0);
    step();
    load_beat(14'h2789);
    run_start();
    expect_issue("t6_reload", 1'b1, 14'h2789, 4'd0); step();
    expect_done_then_idle("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
